// File: rtl/newhope_pkg.sv
// Shared NewHope constants: ring size, modulus, coefficient widths and the
// Barrett reduction parameters used by the pointwise and NTT datapaths.
package newhope_pkg;
  localparam int N         = 512;
  localparam int LOGN      = 9;
  localparam int Q         = 12289;
  localparam int COEF_W    = 16;
  localparam int COEF_BITS = 14;
  localparam int SUM_W     = 28;
  // K equal to the sum width keeps the qhat underestimate at most 1 for every s < 2^28.
  localparam int BARRETT_K = 28;
  localparam int BARRETT_M = (1 << BARRETT_K) / Q;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } mac_state_e;
endpackage

// File: rtl/mod_q_reduce.sv
// Three-register Barrett reduction of a 28-bit value modulo Q: estimate the
// quotient, subtract qhat*Q, then apply one conditional subtraction of Q.
module mod_q_reduce
  import newhope_pkg::SUM_W, newhope_pkg::COEF_BITS, newhope_pkg::BARRETT_K;
#(
  parameter int Q = newhope_pkg::Q
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SUM_W-1:0]     s_i,
  output logic [COEF_BITS-1:0] r_o
);
  localparam int M      = (1 << BARRETT_K) / Q;
  localparam int M_W    = 16;
  localparam int PROD_W = SUM_W + M_W;
  localparam int QH_W   = PROD_W - BARRETT_K;
  localparam int T_W    = COEF_BITS + 1;

  logic [SUM_W-1:0]     s_d, s_q;
  logic [QH_W-1:0]      qhat_d, qhat_q;
  logic [T_W-1:0]       t_d, t_q;
  logic [COEF_BITS-1:0] r_d, r_q;
  logic [PROD_W-1:0]    prod;
  logic [SUM_W-1:0]     qhat_times_q;

  always_comb begin
    s_d          = s_q;
    qhat_d       = qhat_q;
    t_d          = t_q;
    r_d          = r_q;
    prod         = PROD_W'(s_i) * PROD_W'(M);
    qhat_times_q = SUM_W'(qhat_q) * SUM_W'(Q);
    if (en) begin
      s_d    = s_i;
      qhat_d = QH_W'(prod >> BARRETT_K);
      // qhat is at most one short of floor(s/Q), so t lands in [0, 2Q).
      t_d    = T_W'(s_q - qhat_times_q);
      r_d    = (t_q >= T_W'(Q)) ? COEF_BITS'(t_q - T_W'(Q)) : COEF_BITS'(t_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      qhat_q <= '0;
      t_q    <= '0;
      r_q    <= '0;
    end else begin
      s_q    <= s_d;
      qhat_q <= qhat_d;
      t_q    <= t_d;
      r_q    <= r_d;
    end
  end

  assign r_o = r_q;
endmodule

// File: rtl/poly_pointwise_mac.sv
// Pointwise r[i] = (a[i]*b[i] + c[i]) mod Q over a whole polynomial: one shared
// read address for three source RAMs, a 5-cycle pipeline into the result RAM.
module poly_pointwise_mac #(
  parameter int N      = newhope_pkg::N,
  parameter int Q      = newhope_pkg::Q,
  parameter int COEF_W = newhope_pkg::COEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  output logic                 done,
  output logic [$clog2(N)-1:0] addr_rd,
  input  logic [COEF_W-1:0]    din_a,
  input  logic [COEF_W-1:0]    din_b,
  input  logic [COEF_W-1:0]    din_c,
  output logic                 we_r,
  output logic [$clog2(N)-1:0] addr_r,
  output logic [COEF_W-1:0]    dout_r
);
  import newhope_pkg::mac_state_e, newhope_pkg::ST_IDLE, newhope_pkg::ST_RUN, newhope_pkg::ST_DRAIN;
  import newhope_pkg::SUM_W, newhope_pkg::COEF_BITS;

  localparam int AW = $clog2(N);

  mac_state_e            state_d, state_q;
  logic [AW-1:0]         addr_rd_d, addr_rd_q;
  // valid[k] and pipe_addr[k] describe the coefficient sitting in stage Sk.
  logic [5:0]            valid_d, valid_q;
  logic [5:1][AW-1:0]    pipe_addr_d, pipe_addr_q;
  logic [SUM_W-1:0]      sum_d, sum_q;
  logic                  done_d, done_q;
  logic                  last_out;
  logic [COEF_BITS-1:0]  red;
  logic                  unused_din_hi;

  assign unused_din_hi = ^{din_a[COEF_W-1:COEF_BITS], din_b[COEF_W-1:COEF_BITS],
                           din_c[COEF_W-1:COEF_BITS]};

  always_comb begin
    state_d     = state_q;
    addr_rd_d   = addr_rd_q;
    valid_d     = valid_q;
    pipe_addr_d = pipe_addr_q;
    sum_d       = sum_q;
    done_d      = 1'b0;
    last_out    = valid_q[5] && (pipe_addr_q[5] == AW'(N - 1));
    if (en) begin
      valid_d     = {valid_q[4:0], 1'b0};
      pipe_addr_d = {pipe_addr_q[4:1], addr_rd_q};
      sum_d       = SUM_W'(din_a[COEF_BITS-1:0]) * SUM_W'(din_b[COEF_BITS-1:0])
                  + SUM_W'(din_c[COEF_BITS-1:0]);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_RUN;
            addr_rd_d  = '0;
            valid_d[0] = 1'b1;
          end
        end
        ST_RUN: begin
          if (addr_rd_q == AW'(N - 1)) begin
            state_d   = ST_DRAIN;
            addr_rd_d = '0;
          end else begin
            addr_rd_d  = addr_rd_q + AW'(1);
            valid_d[0] = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_out) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_rd_q   <= '0;
      valid_q     <= '0;
      pipe_addr_q <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_rd_q   <= addr_rd_d;
      valid_q     <= valid_d;
      pipe_addr_q <= pipe_addr_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
    end
  end

  mod_q_reduce #(
    .Q(Q)
  ) u_reduce (
    .clk(clk),
    .rst(rst),
    .en (en),
    .s_i(sum_q),
    .r_o(red)
  );

  assign done    = done_q;
  assign addr_rd = addr_rd_q;
  assign we_r    = valid_q[5] & en;
  assign addr_r  = pipe_addr_q[5];
  assign dout_r  = COEF_W'(red);
endmodule

// File: tb/tb_poly_pointwise_mac.sv
// Self-checking bench for poly_pointwise_mac: behavioural RAMs, golden
// (a*b+c)%Q model, timing/ordering checks, stalls, reset and restart corners.
module tb_poly_pointwise_mac;
  import newhope_pkg::*;

  typedef struct {
    int a;
    int b;
    int c;
    int exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [8:0]  addr_rd;
  logic [8:0]  addr_r;
  logic [15:0] din_a = '0;
  logic [15:0] din_b = '0;
  logic [15:0] din_c = '0;
  logic        we_r;
  logic [15:0] dout_r;

  always #5 clk = ~clk;

  poly_pointwise_mac dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .done(done),
    .addr_rd(addr_rd), .din_a(din_a), .din_b(din_b), .din_c(din_c),
    .we_r(we_r), .addr_r(addr_r), .dout_r(dout_r)
  );

  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [15:0] mem_c [N];

  always @(posedge clk) begin
    if (en) begin
      din_a <= mem_a[addr_rd];
      din_b <= mem_b[addr_rd];
      din_c <= mem_c[addr_rd];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int res    [N];
  int golden [N];
  int saved  [N];
  int run_k, first_we, last_we, done_cyc, done_cnt, nwr, order_bad, bad_en, en_hi;
  int next_k = -1;
  bit aborted;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int a, input int b, input int c);
    return (a * b + c) % Q;
  endfunction

  task automatic fill_golden();
    for (int i = 0; i < N; i++)
      golden[i] = model(int'(mem_a[i]), int'(mem_b[i]), int'(mem_c[i]));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'($urandom_range(0, Q - 1));
      mem_b[i] = 16'($urandom_range(0, Q - 1));
      mem_c[i] = 16'($urandom_range(0, Q - 1));
    end
  endtask

  // One run, driven and observed cycle by cycle from this single process.
  task automatic run_once(input int en_pct, input int spur_addr, input int rst_addr, input bit chain);
    bit seen_done = 1'b0;
    bit spur_used = 1'b0;
    bit fin = 1'b0;
    int tail = 0;
    for (int i = 0; i < N; i++) res[i] = -1;
    nwr = 0; order_bad = 0; bad_en = 0; first_we = -1; last_we = -1;
    done_cnt = 0; done_cyc = -1; aborted = 1'b0;
    if (next_k < 0) begin
      start = 1'b1;
      en    = 1'b1;
      run_k = cyc;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      run_k  = next_k;
      next_k = -1;
    end
    en_hi = 1;
    for (int it = 0; it < 4 * N && !fin; it++) begin
      en = (en_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < en_pct);
      if (spur_addr >= 0 && !spur_used && int'(addr_rd) == spur_addr) begin
        start     = 1'b1;
        en        = 1'b1;
        spur_used = 1'b1;
      end
      @(negedge clk);
      if (it == 0) chk("first_addr_rd", 32'(addr_rd), 0);
      if (we_r) begin
        if (!en) bad_en++;
        if (int'(addr_r) != nwr) order_bad++;
        res[addr_r] = int'(dout_r);
        nwr++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (rst_addr >= 0 && int'(addr_rd) == rst_addr) begin
        rst = 1'b0;
        #1;
        chk("rst_done", 32'(done), 0);
        chk("rst_we_r", 32'(we_r), 0);
        chk("rst_addr_rd", 32'(addr_rd), 0);
        chk("rst_addr_r", 32'(addr_r), 0);
        chk("rst_dout_r", 32'(dout_r), 0);
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (seen_done) begin
        if (done) done_cnt++;
        tail++;
        if (tail >= 8) fin = 1'b1;
      end else if (done) begin
        seen_done = 1'b1;
        done_cnt++;
        done_cyc = cyc;
        if (chain) begin
          start  = 1'b1;
          en     = 1'b1;
          next_k = cyc;
          fin    = 1'b1;
        end
      end else if (en) begin
        en_hi++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (!seen_done && !aborted) chk("done_timeout", 0, 1);
  endtask

  task automatic check_run(input string tag, input bit exact_timing);
    int bad = 0;
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_writes"}, nwr, N);
    chk({tag, "_order_bad"}, order_bad, 0);
    chk({tag, "_we_while_en0"}, bad_en, 0);
    chk({tag, "_en_high_cycles"}, en_hi, N + 6);
    if (exact_timing) begin
      chk({tag, "_first_we_cycle"}, first_we - run_k, 6);
      chk({tag, "_last_we_cycle"}, last_we - run_k, N + 5);
      chk({tag, "_done_cycle"}, done_cyc - run_k, N + 6);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res[i] != golden[i]) begin
        errors++;
        if (bad < 4)
          $display("FAIL %s_coef[%0d]: got %0d expected %0d", tag, i, res[i], golden[i]);
        bad++;
      end
    end
  endtask

  initial begin
    int bad;
    vecs = '{'{1, 1, 0, 1}, '{12288, 12288, 12288, 0}, '{12288, 12288, 0, 1},
             '{0, 5, 12288, 12288}, '{12288, 1, 0, 12288}, '{2, 6145, 0, 1},
             '{100, 200, 300, 8011}, '{12288, 12288, 1, 2},
             '{12288, 12288, 12287, 12288}};
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 32'(done), 0);
    chk("reset_we_r", 32'(we_r), 0);
    chk("reset_addr_rd", 32'(addr_rd), 0);
    chk("reset_addr_r", 32'(addr_r), 0);
    chk("reset_dout_r", 32'(dout_r), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // All-ones run: every result is 1, exact cycle timing.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'd1; mem_b[i] = 16'd1; mem_c[i] = 16'd0;
    end
    fill_golden();
    run_once(100, -1, -1, 1'b0);
    check_run("ones", 1'b1);
    chk("ones_coef0_const", res[0], 1);
    chk("ones_coef511_const", res[N-1], 1);

    // Random operands with the boundary table planted at both ends.
    fill_random();
    for (int v = 0; v < 9; v++) begin
      mem_a[v] = 16'(vecs[v].a); mem_b[v] = 16'(vecs[v].b); mem_c[v] = 16'(vecs[v].c);
      mem_a[N-1-v] = 16'(vecs[v].a); mem_b[N-1-v] = 16'(vecs[v].b); mem_c[N-1-v] = 16'(vecs[v].c);
    end
    fill_golden();
    run_once(100, -1, -1, 1'b0);
    check_run("rand", 1'b1);
    for (int v = 0; v < 9; v++) begin
      chk($sformatf("vec%0d_lo", v), res[v], vecs[v].exp);
      chk($sformatf("vec%0d_hi", v), res[N-1-v], vecs[v].exp);
    end
    for (int i = 0; i < N; i++) saved[i] = res[i];

    // Same data with en toggling at roughly 50% duty.
    run_once(50, -1, -1, 1'b0);
    check_run("en50", 1'b0);
    bad = 0;
    for (int i = 0; i < N; i++) if (res[i] != saved[i]) bad++;
    chk("en50_vs_en1_diffs", bad, 0);

    // Reset mid-run at address 200, then a fresh full run.
    run_once(100, -1, 200, 1'b0);
    chk("rst_run_aborted", 32'(aborted), 1);
    rst = 1'b1;
    bad = 0;
    en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (we_r || done || addr_rd != 9'd0) bad++;
      @(posedge clk); #1;
    end
    chk("idle_after_rst", bad, 0);
    fill_random();
    fill_golden();
    run_once(100, -1, -1, 1'b0);
    check_run("post_rst", 1'b1);

    // Spurious start at address 100 must be ignored.
    run_once(100, 100, -1, 1'b0);
    check_run("spur", 1'b1);

    // Start in the done cycle chains straight into a second run.
    fill_random();
    fill_golden();
    run_once(100, -1, -1, 1'b1);
    check_run("chain_a", 1'b1);
    chk("chain_started", 32'(next_k >= 0), 1);
    run_once(100, -1, -1, 1'b0);
    check_run("chain_b", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
